// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts_pkg
// Description : Shared MPEG-2 TS constants and synchroniser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE  = 8'h47;
  localparam int         TS_PKT_LEN    = 188;
  localparam int         TS_RS_PKT_LEN = 204;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;

endpackage
`default_nettype wire

// File: rtl/ts_sync_lock_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter, holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ts_sync_lock.sv
`default_nettype none
// ============================================================================
// Module      : ts_sync_lock
// Description : MPEG-2 TS packet synchroniser with lock/unlock hysteresis,
//               flywheel tagging and a saturating sync-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_sync_lock
  import ts_pkg::*;
#(
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         LOCK_CNT   = 5,
  parameter int         UNLOCK_CNT = 3,
  parameter int         ERR_W      = 16,
  parameter int         IDX_W      = $clog2(PKT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             valid,
  output logic [7:0]       byte_out,
  output logic             locked,
  output logic             sop,
  output logic             eop,
  output logic [IDX_W-1:0] byte_idx,
  output logic             lost,
  output logic [ERR_W-1:0] sync_err_cnt
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [IDX_W-1:0]  LAST_POS   = IDX_W'(PKT_LEN - 1);
  localparam logic [HIT_W-1:0]  LOCK_HITS  = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] DROP_MISS  = MISS_W'(UNLOCK_CNT);

  ts_state_e         state_d, state_q;
  logic [IDX_W-1:0]  pos_d, pos_q;
  logic [HIT_W-1:0]  hits_d, hits_q;
  logic [MISS_W-1:0] misses_d, misses_q;
  logic              valid_d, valid_q;
  logic [7:0]        byte_d, byte_q;
  logic              locked_d, locked_q;
  logic              sop_d, sop_q;
  logic              eop_d, eop_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              lost_d, lost_q;
  logic              err_inc;

  logic [IDX_W-1:0]  pos_next;
  logic [HIT_W-1:0]  hits_inc;
  logic [MISS_W-1:0] misses_inc;
  logic              is_sync;
  logic              at_exp;

  assign pos_next   = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
  assign hits_inc   = hits_q + 1'b1;
  assign misses_inc = misses_q + 1'b1;
  assign is_sync    = (byte_in == SYNC_BYTE);
  assign at_exp     = (pos_q == '0);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    err_inc  = 1'b0;
    valid_d  = byte_valid;
    byte_d   = byte_in;
    locked_d = locked_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    idx_d    = idx_q;
    lost_d   = 1'b0;

    if (byte_valid) begin
      case (state_q)
        SEARCH: begin
          if (is_sync) begin
            pos_d   = IDX_W'(1);
            hits_d  = HIT_W'(1);
            state_d = CHECK;
          end
        end
        CHECK: begin
          pos_d = pos_next;
          if (at_exp) begin
            if (is_sync) begin
              hits_d = hits_inc;
              if (hits_inc == LOCK_HITS) begin
                state_d  = LOCKED;
                misses_d = '0;
              end
            end else begin
              state_d = SEARCH;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_next;
          if (at_exp) begin
            if (is_sync) begin
              misses_d = '0;
            end else begin
              misses_d = misses_inc;
              err_inc  = 1'b1;
              if (misses_inc == DROP_MISS) begin
                state_d = SEARCH;
                lost_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = SEARCH;
      endcase

      // Tags follow the post-decision state so the locking/unlocking byte is marked correctly
      locked_d = (state_d == LOCKED);
      sop_d    = locked_d && at_exp;
      eop_d    = locked_d && (pos_q == LAST_POS);
      idx_d    = locked_d ? pos_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      pos_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      valid_q  <= 1'b0;
      byte_q   <= '0;
      locked_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      idx_q    <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      locked_q <= locked_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      idx_q    <= idx_d;
      lost_q   <= lost_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .count(sync_err_cnt)
  );

  assign valid    = valid_q;
  assign byte_out = byte_q;
  assign locked   = locked_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign byte_idx = idx_q;
  assign lost     = lost_q;

endmodule
`default_nettype wire

// File: doc/ts_sync_lock.md
# ts_sync_lock

Parametrised MPEG-2 TS packet synchroniser with configurable packet length, lock and unlock hysteresis, and flywheel behaviour. It sits directly behind the byte deserialiser and ahead of PID filtering and QoS counters. It passes every input byte through with one cycle of latency. Once locked, it tags each output byte with packet position, start-of-packet and end-of-packet. It also counts sync errors seen while locked.

## Interface
- PKT_LEN, 188: bytes per packet; legal values are 188 or 204 (RS-coded).
- SYNC_BYTE, 8'h47: sync byte value.
- LOCK_CNT, 5: consecutive correctly spaced sync bytes required to declare lock, first one included; must be ≥2.
- UNLOCK_CNT, 3: consecutive missing sync bytes while locked that drop lock; must be ≥1.
- ERR_W, 16: width of the sync error counter.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  input byte.
- byte_valid  in  1  byte_in qualifier.
- valid  out  1  byte_out qualifier.
- byte_out  out  8  delayed copy of byte_in.
- locked  out  1  lock status (level).
- sop  out  1  byte_out is byte 0 of a packet; only asserted while locked.
- eop  out  1  byte_out is byte PKT_LEN-1; only asserted while locked.
- byte_idx  out  $clog2(PKT_LEN)  position of byte_out in its packet; 0 when not locked.
- lost  out  1  one-cycle pulse when lock drops.
- sync_err_cnt  out  ERR_W  saturating count of missing syncs while locked.

## Operation
- Reset: all outputs 0. State returns to SEARCH. Internal counters clear.
- Cycles with byte_valid=0:
  - No state or counter change.
  - valid, sop, eop and lost are 0.
  - locked, byte_idx and sync_err_cnt hold.
- pos is an internal packet position counter, 0..PKT_LEN-1. It advances by 1 on each valid byte and wraps from PKT_LEN-1 to 0. The byte at pos==0 is the "expected sync".
- SEARCH:
  - Valid byte equal to SYNC_BYTE → pos:=1, hits:=1, go to CHECK.
  - Otherwise stay.
- CHECK:
  - At expected sync, if byte==SYNC_BYTE: hits+=1. If the new hits==LOCK_CNT → go to LOCKED, set locked=1, misses:=0.
  - At expected sync, if byte!=SYNC_BYTE → go to SEARCH. That byte is not re-evaluated as a candidate.
- LOCKED:
  - At expected sync, if byte==SYNC_BYTE → misses:=0.
  - At expected sync, if byte!=SYNC_BYTE → misses+=1 and sync_err_cnt+=1, saturating at all-ones.
  - If the new misses==UNLOCK_CNT → go to SEARCH, set locked=0, pulse lost.
  - Flywheel: below UNLOCK_CNT, pos keeps counting and sop/eop/byte_idx continue as if the sync had been present.
- sync_err_cnt is cleared only by rst, never on unlock.
- A sync-valued byte at a non-expected position is ignored in CHECK and LOCKED.

## Timing
- Latency is 1 cycle: valid and byte_out are registered copies of byte_valid and byte_in.
- All tags (sop, eop, byte_idx, locked, lost) are registered and aligned with the byte_out they describe.
- Lock: the LOCK_CNT-th sync byte appears on byte_out with locked=1, sop=1, byte_idx=0.
- Unlock: the UNLOCK_CNT-th missing sync byte appears on byte_out with locked=0, sop=0, byte_idx=0, lost=1.
- On a flywheeled miss, that byte is output with sop=1 and sync_err_cnt already incremented.
- eop is asserted on byte_idx==PKT_LEN-1 while locked.
- With LOCK_CNT=5, PKT_LEN=188 and continuous valid data, locked rises 4×188+1 cycles after the first sync is presented.
- Asserting rst mid-packet clears everything on the next edge; no partial-packet tags follow.

## Structure
- Shared package ts_pkg holds:
  - TS_SYNC_BYTE (8'h47)
  - TS_PKT_LEN (188)
  - TS_RS_PKT_LEN (204)
  - the state enum {SEARCH, CHECK, LOCKED}
- The package is reused by PID filter and QoS blocks.
- A single module is sufficient. The saturating error counter may be factored into sat_counter (parameter W) for reuse by QoS counters.

## Test plan
- Clean stream, PKT_LEN=188, LOCK_CNT=5: first sync at cycle 10 → locked=1 on the 5th sync's byte_out; sop every 188 valid bytes; eop on byte_idx=187; sync_err_cnt=0.
- Corrupt the 3rd sync during CHECK (0x00) → no lock. Resync from the next 0x47 needs 5 further good syncs.
- Locked, UNLOCK_CNT=3, corrupt 2 consecutive syncs → locked stays 1, sop still marked, sync_err_cnt=2. Then one good sync → misses cleared; corrupting 2 more keeps lock.
- Locked, corrupt 3 consecutive syncs → lost=1 for one cycle with the 3rd bad byte; locked=0; sop/eop stop; sync_err_cnt=3.
- PKT_LEN=204 stream with random byte_valid gaps (≈30% idle) → lock and sop spacing count valid bytes only; tags unchanged by gaps.
- Reset mid-packet while locked → all outputs 0 the cycle after rst. ERR_W=4 saturation test: 20 misses with UNLOCK_CNT=32 → sync_err_cnt=15.
